div_unit: RTL and testbench

Multi-cycle 32-bit integer divider in the execute stage of the 5-stage MIPS pipeline. It implements DIV and DIVU with a radix-2 restoring algorithm, one quotient bit per cycle. It also produces the execute-stage divide stall, which the hazard unit ORs into its stall and flush terms. The {HI, LO} result is written to the HI/LO register pair when the instruction leaves execute.

---
 rtl/div_unit.sv | 126 ++++++++++++
 tb/tb_div_unit.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// ============================================================================
// Module      : div_unit
// Description : Radix-2 restoring divider for DIV/DIVU, one quotient bit per
//               cycle, with execute-stage stall generation and {HI, LO} result.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 startE,
    input  logic                 signedE,
    input  logic [WIDTH-1:0]     srcaE,
    input  logic [WIDTH-1:0]     srcbE,
    input  logic                 annulE,
    output logic                 div_stallE,
    output logic                 readyE,
    output logic [2*WIDTH-1:0]   resultE
);

    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                r_state;
    logic [WIDTH-1:0]      r_rem;
    logic [WIDTH-1:0]      r_quo;
    logic [WIDTH-1:0]      r_divisor;
    logic [CNT_W-1:0]      r_count;
    logic                  r_quoNeg;
    logic                  r_remNeg;
    logic [2*WIDTH-1:0]    r_pending;
    logic [2*WIDTH-1:0]    r_result;

    logic [WIDTH-1:0]      w_absA;
    logic [WIDTH-1:0]      w_absB;
    logic [WIDTH:0]        w_shifted;
    logic [WIDTH:0]        w_diff;
    logic                  w_neg;
    logic [WIDTH-1:0]      w_nextRem;
    logic [WIDTH-1:0]      w_nextQuo;
    logic [WIDTH-1:0]      w_finalRem;
    logic [WIDTH-1:0]      w_finalQuo;
    logic                  w_lastBit;

    assign w_absA = (signedE && srcaE[WIDTH-1]) ? -srcaE : srcaE;
    assign w_absB = (signedE && srcbE[WIDTH-1]) ? -srcbE : srcbE;

    // Partial remainder is always below the divisor, so a WIDTH+1-bit
    // difference is enough for its top bit to act as the borrow.
    assign w_shifted  = {r_rem, r_quo[WIDTH-1]};
    assign w_diff     = w_shifted - {1'b0, r_divisor};
    assign w_neg      = w_diff[WIDTH];
    assign w_nextRem  = w_neg ? w_shifted[WIDTH-1:0] : w_diff[WIDTH-1:0];
    assign w_nextQuo  = {r_quo[WIDTH-2:0], ~w_neg};
    assign w_finalQuo = r_quoNeg ? -w_nextQuo : w_nextQuo;
    assign w_finalRem = r_remNeg ? -w_nextRem : w_nextRem;
    assign w_lastBit  = (r_count == CNT_W'(WIDTH - 1));

    assign div_stallE = ((r_state == IDLE) && startE && !annulE) ||
                        ((r_state == RUN) && !annulE);
    assign readyE     = (r_state == DONE) && !annulE;

    // The new result is visible during DONE but only committed when the
    // instruction actually leaves execute, so an annul in DONE leaves it intact.
    assign resultE    = ((r_state == DONE) && !annulE) ? r_pending : r_result;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_rem     <= '0;
            r_quo     <= '0;
            r_divisor <= '0;
            r_count   <= '0;
            r_quoNeg  <= 1'b0;
            r_remNeg  <= 1'b0;
            r_pending <= '0;
            r_result  <= '0;
        end else if (annulE) begin
            r_state <= IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (startE) begin
                        r_rem     <= '0;
                        r_count   <= '0;
                        r_quo     <= w_absA;
                        r_divisor <= w_absB;
                        r_quoNeg  <= signedE && (srcaE[WIDTH-1] ^ srcbE[WIDTH-1]);
                        r_remNeg  <= signedE && srcaE[WIDTH-1];
                        if (srcbE == '0) begin
                            r_pending <= {srcaE, {WIDTH{1'b1}}};
                            r_state   <= DONE;
                        end else begin
                            r_state   <= RUN;
                        end
                    end
                end
                RUN: begin
                    r_rem   <= w_nextRem;
                    r_quo   <= w_nextQuo;
                    r_count <= r_count + 1'b1;
                    if (w_lastBit) begin
                        r_pending <= {w_finalRem, w_finalQuo};
                        r_state   <= DONE;
                    end
                end
                DONE: begin
                    r_result <= r_pending;
                    r_state  <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_div_unit.sv
// Scoreboarded directed test for div_unit: a queue of expected {HI, LO}
// results is drained by a monitor whenever readyE pulses.
`default_nettype none

module tb_div_unit;

    logic        clk;
    logic        rst;
    logic        startE;
    logic        signedE;
    logic [31:0] srcaE;
    logic [31:0] srcbE;
    logic        annulE;
    logic        div_stallE;
    logic        readyE;
    logic [63:0] resultE;

    int          errors = 0;
    int          checks = 0;
    int          cycle  = 0;
    logic [63:0] expQ[$];
    logic [63:0] lastResult;

    div_unit #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .startE    (startE),
        .signedE   (signedE),
        .srcaE     (srcaE),
        .srcbE     (srcbE),
        .annulE    (annulE),
        .div_stallE(div_stallE),
        .readyE    (readyE),
        .resultE   (resultE)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every readyE pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst === 1'b1 && readyE === 1'b1) begin
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ready: got readyE=1 result %h expected no pulse", resultE);
            end else begin
                check("result", resultE, expQ.pop_front());
            end
        end
    end

    task automatic waitReady(output int stallCnt, output int lat, output bit ok);
        stallCnt = 0;
        lat      = 0;
        ok       = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            lat++;
            if (div_stallE) stallCnt++;
            if (readyE) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL timeout: got no readyE in %0d cycles expected a pulse", lat);
        end
    endtask

    task automatic doDiv(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp, input int expStall);
        int  stallCnt;
        int  lat;
        bit  ok;
        @(posedge clk);
        #1;
        startE  = 1'b1;
        signedE = sgn;
        srcaE   = a;
        srcbE   = b;
        expQ.push_back(exp);
        waitReady(stallCnt, lat, ok);
        if (ok) begin
            check("stall_cycles", 64'(stallCnt), 64'(expStall));
            check("ready_latency", 64'(lat), 64'(expStall + 1));
        end
        @(posedge clk);
        #1;
        startE = 1'b0;
        lastResult = exp;
        @(negedge clk);
        check("result_hold", resultE, exp);
        check("ready_single_pulse", 64'(readyE), 64'd0);
    endtask

    initial begin
        int  stallCnt;
        int  lat;
        bit  ok;
        int  c1;

        rst = 1'b0; startE = 1'b0; signedE = 1'b0;
        srcaE = '0; srcbE = '0; annulE = 1'b0;
        lastResult = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_stall", 64'(div_stallE), 64'd0);
        check("reset_ready", 64'(readyE), 64'd0);
        check("reset_result", resultE, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        doDiv(1'b0, 32'd100,        32'd7,        {32'h00000002, 32'h0000000E}, 33);
        doDiv(1'b1, 32'hFFFFFFF9,   32'h2,        {32'hFFFFFFFF, 32'hFFFFFFFD}, 33);
        doDiv(1'b0, 32'hFFFFFFF9,   32'h2,        {32'h00000001, 32'h7FFFFFFC}, 33);
        doDiv(1'b1, 32'd7,          32'hFFFFFFFE, {32'h00000001, 32'hFFFFFFFD}, 33);
        doDiv(1'b1, 32'h80000000,   32'hFFFFFFFF, {32'h00000000, 32'h80000000}, 33);
        doDiv(1'b0, 32'd5,          32'd0,        {32'h00000005, 32'hFFFFFFFF}, 1);
        doDiv(1'b1, 32'hFFFFFFF9,   32'd0,        {32'hFFFFFFF9, 32'hFFFFFFFF}, 1);

        // Annul at RUN cycle 10: stall drops at once, no result is produced.
        @(posedge clk);
        #1;
        startE = 1'b1; signedE = 1'b0; srcaE = 32'd1000; srcbE = 32'd3;
        repeat (10) @(posedge clk);
        #1;
        annulE = 1'b1;
        @(negedge clk);
        check("annul_stall", 64'(div_stallE), 64'd0);
        check("annul_ready", 64'(readyE), 64'd0);
        @(posedge clk);
        #1;
        annulE = 1'b0;
        startE = 1'b0;
        repeat (40) @(negedge clk);
        check("annul_result_kept", resultE, lastResult);
        check("annul_idle_stall", 64'(div_stallE), 64'd0);
        doDiv(1'b0, 32'd9, 32'd3, {32'h0, 32'h3}, 33);

        // One-cycle reset at RUN cycle 20 discards the divide.
        @(posedge clk);
        #1;
        startE = 1'b1; signedE = 1'b0; srcaE = 32'd1000; srcbE = 32'd3;
        repeat (20) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        startE = 1'b0;
        @(negedge clk);
        check("midrun_reset_stall", 64'(div_stallE), 64'd0);
        check("midrun_reset_ready", 64'(readyE), 64'd0);
        check("midrun_reset_result", resultE, 64'd0);
        doDiv(1'b0, 32'd8, 32'd2, {32'h0, 32'h4}, 33);

        // Back-to-back with startE held through DONE.
        @(posedge clk);
        #1;
        startE = 1'b1; signedE = 1'b0; srcaE = 32'd100; srcbE = 32'd7;
        expQ.push_back({32'h00000002, 32'h0000000E});
        waitReady(stallCnt, lat, ok);
        c1 = cycle;
        signedE = 1'b1; srcaE = 32'hFFFFFFF9; srcbE = 32'h2;
        expQ.push_back({32'hFFFFFFFF, 32'hFFFFFFFD});
        waitReady(stallCnt, lat, ok);
        if (ok) begin
            check("b2b_spacing", 64'(cycle - c1), 64'd34);
            check("b2b_stall_cycles", 64'(stallCnt), 64'd33);
        end
        @(posedge clk);
        #1;
        startE = 1'b0;
        @(negedge clk);
        check("b2b_result_hold", resultE, {32'hFFFFFFFF, 32'hFFFFFFFD});

        repeat (5) @(negedge clk);
        check("scoreboard_drained", 64'(expQ.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
